udm_uart_rx: RTL and testbench

UDM_UART_RX -- requirements
Module: udm_uart_rx

---
 rtl/udm_uart_pkg.sv | 13 +
 rtl/udm_baud_cnt.sv | 17 +
 rtl/udm_uart_rx.sv | 116 +++++++++++
 tb/tb_udm_uart_rx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/udm_uart_pkg.sv
// udm_uart_pkg: shared FSM state encodings, stop-bit encodings and divider floor for the UDM UART receiver.
package udm_uart_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_DATA  = 3'd2;
  localparam state_t S_STOP  = 3'd3;
  localparam state_t S_STOP2 = 3'd4;
  localparam state_t S_WAIT  = 3'd5;
  localparam logic [1:0] NSTOP_1 = 2'b00;
  localparam logic [1:0] NSTOP_2 = 2'b01;
  localparam logic [31:0] MIN_DIV = 32'd2;
endpackage

// File: rtl/udm_baud_cnt.sv
// udm_baud_cnt: loadable down-counter; tc_o flags the last cycle of a loaded period while running.
module udm_baud_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        run_i,
  input  logic [31:0] load_val_i,
  output logic        tc_o
);
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (run_i && cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end
  assign tc_o = run_i && cnt_q == 32'd1;
endmodule

// File: rtl/udm_uart_rx.sv
// udm_uart_rx: 8N1/8N2 UART receiver with valid/ready byte output, frame-error and overrun pulses.
module udm_uart_rx
  import udm_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [31:0] divider_i,
  input  logic [1:0]  nstop_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        overrun_o
);
  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic        line, line_ok, start, tc, run, done, err;
  logic [31:0] div_in, div_q, div_d;
  logic [1:0]  nstop_q, nstop_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic        armed_q, armed_d, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  state_t      state_q, state_d;

  assign line    = sync_q[SYNC_STAGES-1];
  // fill_q marks when line carries a real post-reset sample, so a low line held through reset is not a start
  assign line_ok = fill_q[SYNC_STAGES-1];
  assign div_in  = (divider_i < MIN_DIV) ? MIN_DIV : divider_i;
  assign start   = state_q == S_IDLE && armed_q && line_ok && !line;
  assign run     = state_q != S_IDLE && state_q != S_WAIT;

  udm_baud_cnt u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (start || tc),
    .run_i      (run),
    .load_val_i (start ? div_in >> 1 : div_q),
    .tc_o       (tc)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    err     = 1'b0;
    armed_d = !start && (armed_q || (line_ok && line));
    div_d   = start ? div_in : div_q;
    nstop_d = start ? nstop_i : nstop_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_START : S_IDLE;
      S_START: if (tc) begin
        state_d = line ? S_IDLE : S_DATA;
        bit_d   = 3'd0;
      end
      S_DATA:  if (tc) begin
        shift_d = {line, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP:  if (tc) begin
        err     = !line;
        done    = line && nstop_q != NSTOP_2;
        state_d = !line ? S_WAIT : (nstop_q == NSTOP_2) ? S_STOP2 : S_IDLE;
      end
      S_STOP2: if (tc) begin
        err     = !line;
        done    = line;
        state_d = line ? S_IDLE : S_WAIT;
      end
      S_WAIT:  state_d = line ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
    valid_d = done || (valid_q && !ready_i);
    data_d  = (done && (!valid_q || ready_i)) ? shift_q : data_q;
    ovr_d   = done && valid_q && !ready_i;
    ferr_d  = err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      fill_q  <= '0;
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      div_q   <= 32'd0;
      nstop_q <= NSTOP_1;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      state_q <= state_d;
      armed_q <= armed_d;
      div_q   <= div_d;
      nstop_q <= nstop_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_udm_uart_rx.sv
// tb_udm_uart_rx: directed UART frames with a byte scoreboard and pulse counters checked by a negedge monitor.
module tb_udm_uart_rx;
  localparam int D = 16;
  localparam int LAT = D / 2 + 9 * D + 1;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b1;
  logic [31:0] div = 32'd16;
  logic [1:0] nstop = 2'b00;
  logic [7:0] data, e;
  logic valid, ferr, ovr;
  int checks = 0, failures = 0, cyc = 0, mark = -1, ferr_cnt = 0, ovr_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udm_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .divider_i(div), .nstop_i(nstop),
    .data_o(data), .valid_o(valid), .ready_i(ready), .frame_err_o(ferr), .overrun_o(ovr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h required=none", data);
      end else begin
        e = exp_q.pop_front();
        chk("rx_byte", {24'd0, data}, {24'd0, e});
        if (mark >= 0) begin
          chk("latency", cyc - mark, LAT + 2);
          mark = -1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_stop, input int nst);
    rx = 1'b0;
    idle(D);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(D);
    end
    rx = !bad_stop;
    idle(D);
    if (nst == 2) idle(D);
    rx = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    idle(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    idle(5);
    exp_q.push_back(8'hA5);
    mark = cyc;
    send(8'hA5, 0, 1);
    idle(20);
    drain();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    chk("glitch_ferr", ferr_cnt, 0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 0, 1);
    idle(20);
    drain();
    send(8'h3C, 1, 1);
    idle(30);
    chk("ferr_cnt", ferr_cnt, 1);
    exp_q.push_back(8'h7E);
    send(8'h7E, 0, 1);
    idle(20);
    drain();
    ready = 1'b0;
    send(8'h11, 0, 1);
    send(8'h22, 0, 1);
    idle(10);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data, 8'h11);
    chk("ovr_cnt", ovr_cnt, 1);
    exp_q.push_back(8'h11);
    ready = 1'b1;
    drain();
    idle(1);
    chk("valid_clear", valid, 0);
    nstop = 2'b01;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send(8'h55, 0, 2);
    send(8'hAA, 0, 2);
    idle(20);
    drain();
    b = 8'hAA;
    rx = 1'b0;
    idle(D);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle(D);
    end
    idle(D / 2);
    rst = 1'b1;
    rx = 1'b1;
    idle(3);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_ferr", ferr, 0);
    chk("mid_rst_ovr", ovr, 0);
    rst = 1'b0;
    idle(200);
    chk("mid_rst_ferr_cnt", ferr_cnt, 1);
    rx = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(60);
    rx = 1'b1;
    idle(10);
    chk("low_rst_ferr_cnt", ferr_cnt, 1);
    exp_q.push_back(8'hC3);
    send(8'hC3, 0, 2);
    idle(30);
    drain();
    chk("final_ovr_cnt", ovr_cnt, 1);
    chk("final_ferr_cnt", ferr_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
